// File: rtl/fetch_unit.sv
// Instruction fetch stage for the pipelined RV32I core.
// Issues sequential word fetches over a valid/ready request channel and
// accepts in-order responses. Returned words go into a small FIFO that is
// presented to decode together with their PC. An Execute-stage redirect
// clears the FIFO. Responses that are still outstanding at the redirect are
// counted off and discarded when they return.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        InstrValidD
);

  localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW        = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [31:0]   NOP       = 32'h0000_0013;

  // Fetch PC and bookkeeping counters
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;

  // PC queue: one entry per outstanding request, in issue order
  logic [31:0]   pcq_q [DEPTH];
  logic [AW-1:0] pcq_rd_q, pcq_rd_d;
  logic [AW-1:0] pcq_wr_q, pcq_wr_d;

  // Instruction buffer
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [31:0]   fifo_pc_q    [DEPTH];
  logic [AW-1:0] fifo_rd_q, fifo_rd_d;
  logic [AW-1:0] fifo_wr_q, fifo_wr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

  logic          req_fire;
  logic          rsp_ok;
  logic          push;
  logic          pop;
  logic [CW:0]   occ;
  logic [31:0]   target_aligned;

  assign target_aligned = PCTargetE & ~32'h0000_0003;

  // Head of the buffer drives decode; NOP/0/0 when the buffer is empty.
  assign InstrValidD = (fifo_cnt_q != '0);
  assign InstrD      = InstrValidD ? fifo_instr_q[fifo_rd_q] : NOP;
  assign PCD         = InstrValidD ? fifo_pc_q[fifo_rd_q] : 32'h0;
  assign PCPlus4D    = InstrValidD ? (fifo_pc_q[fifo_rd_q] + 32'd4) : 32'h0;

  // A redirect suppresses the pop; the whole buffer is flushed instead.
  assign pop    = InstrValidD && !StallD && !PCSrcE;
  assign rsp_ok = imem_rsp_valid && (inflight_q != '0);
  assign push   = rsp_ok && (drop_q == '0) && !PCSrcE;

  // The slot freed by this cycle's pop is credited to issue, so a 1-cycle
  // memory keeps decode fed every cycle. Under stall it is plain
  // buffered + outstanding against DEPTH, which still guarantees every
  // outstanding response a free slot on arrival.
  assign occ = {1'b0, fifo_cnt_q} + {1'b0, inflight_q} - {{CW{1'b0}}, pop};

  assign imem_req_valid = !reset && !PCSrcE && (occ < {1'b0, DEPTH_CNT});
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Next-state for PC, counters and queue pointers
  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_ok);
    drop_d     = drop_q;
    pcq_rd_d   = pcq_rd_q;
    pcq_wr_d   = pcq_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_cnt_d = fifo_cnt_q;

    if (req_fire) begin
      pc_d     = pc_q + 32'd4;
      pcq_wr_d = pcq_wr_q + AW'(1);
    end
    if (rsp_ok) begin
      pcq_rd_d = pcq_rd_q + AW'(1);
    end

    if (PCSrcE) begin
      // Every request still outstanding after this cycle is wrong-path.
      // A response arriving now is dropped here and is not counted again.
      pc_d       = target_aligned;
      drop_d     = inflight_q - CW'(rsp_ok);
      fifo_rd_d  = '0;
      fifo_wr_d  = '0;
      fifo_cnt_d = '0;
    end else begin
      if (rsp_ok && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        fifo_wr_d = fifo_wr_q + AW'(1);
      end
      if (pop) begin
        fifo_rd_d = fifo_rd_q + AW'(1);
      end
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  // State update, with storage writes for issued PCs and returned words
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      pcq_rd_q   <= '0;
      pcq_wr_q   <= '0;
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pcq_q[i]        <= 32'h0;
        fifo_instr_q[i] <= NOP;
        fifo_pc_q[i]    <= 32'h0;
      end
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      pcq_rd_q   <= pcq_rd_d;
      pcq_wr_q   <= pcq_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (req_fire) begin
        pcq_q[pcq_wr_q] <= pc_q;
      end
      if (push) begin
        fifo_instr_q[fifo_wr_q] <= imem_rsp_data;
        fifo_pc_q[fifo_wr_q]    <= pcq_q[pcq_rd_q];
      end
    end
  end

  // A word must never land in a full buffer unless the head leaves the same cycle.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    push |-> ((fifo_cnt_q != DEPTH_CNT) || pop));

  // Memory must not return a word that was never requested.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with programmable latency,
// a reference model of the expected request and delivery PC streams, and
// a monitor that scores every instruction handed to decode.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic        StallD = 1'b0;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        InstrValidD;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .InstrValidD(InstrValidD)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_deliv = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_req_pc = RESET_PC;
  logic [31:0] maddr_q[$];
  int          mdue_q[$];
  int          last_due = 0;
  int          mem_delay = 0;
  bit          rand_lat = 1'b0;

  function automatic logic [31:0] enc(input logic [31:0] a);
    return a ^ 32'hA5A5_0003;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    failures++;
    $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
  endtask

  // expected delivery stream restarts at pc
  task automatic arm_expect(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 400; i++) exp_q.push_back(pc + 32'(4 * i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory: accept at negedge sample, respond in order after 1+delay cycles
  always @(negedge clk) begin
    int d;
    int due;
    if (reset) begin
      maddr_q.delete();
      mdue_q.delete();
      last_due = 0;
    end else if (imem_req_valid && imem_req_ready) begin
      if (PCSrcE) fail_now("req_during_redirect", imem_req_addr, 32'h0);
      chk("req_addr", imem_req_addr, exp_req_pc);
      exp_req_pc = exp_req_pc + 32'd4;
      d = rand_lat ? int'($urandom_range(0, 4)) : mem_delay;
      due = cyc + 1 + d;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      maddr_q.push_back(imem_req_addr);
      mdue_q.push_back(due);
    end
  end

  always @(posedge clk) begin
    cyc++;
    #2;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (!reset && mdue_q.size() > 0 && mdue_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = enc(maddr_q.pop_front());
      void'(mdue_q.pop_front());
    end
  end

  // Scoreboard monitor: every instruction taken by decode
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset && InstrValidD && !StallD && !PCSrcE) begin
      n_deliv++;
      if (exp_q.size() == 0) begin
        fail_now("deliv_unexpected", PCD, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("PCD", PCD, e);
        chk("InstrD", InstrD, enc(e));
        chk("PCPlus4D", PCPlus4D, e + 32'd4);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    PCSrcE = 1'b0;
    PCTargetE = 32'h0;
    StallD = 1'b0;
    imem_req_ready = 1'b1;
    arm_expect(RESET_PC);
    exp_req_pc = RESET_PC;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    PCSrcE = 1'b1;
    PCTargetE = tgt;
    arm_expect(tgt & ~32'h3);
    exp_req_pc = tgt & ~32'h3;
    step();
    PCSrcE = 1'b0;
    PCTargetE = 32'h0;
  endtask

  initial begin
    int base;
    int since;
    bit found;
    logic [31:0] tgt;

    // reset values while held in reset
    step();
    chk("rst_valid", 32'(InstrValidD), 32'h0);
    chk("rst_InstrD", InstrD, NOP);
    chk("rst_PCD", PCD, 32'h0);
    chk("rst_PCPlus4D", PCPlus4D, 32'h0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);

    // release, 1-cycle memory: first word visible 2 cycles later, then 1/cycle
    mem_delay = 0;
    do_reset();
    @(negedge clk);
    chk("c0_valid", 32'(InstrValidD), 32'h0);
    chk("c0_req_valid", 32'(imem_req_valid), 32'h1);
    chk("c0_req_addr", imem_req_addr, RESET_PC);
    @(negedge clk);
    chk("c1_valid", 32'(InstrValidD), 32'h0);
    @(negedge clk);
    chk("c2_valid", 32'(InstrValidD), 32'h1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stream_valid", 32'(InstrValidD), 32'h1);
    end

    // stall 5 cycles: head frozen, issue stops once buffer+outstanding is full
    step();
    StallD = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_PCD", PCD, exp_q[0]);
      chk("stall_InstrD", InstrD, enc(exp_q[0]));
      if (i >= 1) chk("stall_req_valid", 32'(imem_req_valid), 32'h0);
      step();
    end
    StallD = 1'b0;
    repeat (6) step();

    // reset mid-stream with the buffer full
    StallD = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(InstrValidD), 32'h0);
    chk("midrst_InstrD", InstrD, NOP);
    chk("midrst_PCD", PCD, 32'h0);
    chk("midrst_PCPlus4D", PCPlus4D, 32'h0);
    chk("midrst_req_valid", 32'(imem_req_valid), 32'h0);
    do_reset();
    @(negedge clk);
    chk("postrst_req_addr", imem_req_addr, RESET_PC);
    chk("postrst_req_valid", 32'(imem_req_valid), 32'h1);

    // redirect to 0x100 with two requests outstanding
    step();
    mem_delay = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      #3;
      if (maddr_q.size() == 2) found = 1'b1;
    end
    if (!found) fail_now("wait_two_inflight", 32'(maddr_q.size()), 32'h2);
    redirect(32'h0000_0100);
    @(negedge clk);
    chk("redir_valid_n1", 32'(InstrValidD), 32'h0);
    chk("redir_addr_n1", imem_req_addr, 32'h0000_0100);
    repeat (15) step();

    // unaligned target 0x203 fetches from 0x200
    mem_delay = 0;
    redirect(32'h0000_0203);
    @(negedge clk);
    chk("redir203_addr", imem_req_addr, 32'h0000_0200);
    chk("redir203_valid", 32'(InstrValidD), 32'h0);
    repeat (8) step();

    // ready low 3 cycles: address held at 0x8, accepted on the 4th
    do_reset();
    step();
    step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_req_valid", 32'(imem_req_valid), 32'h1);
      chk("hold_req_addr", imem_req_addr, 32'h0000_0008);
      step();
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk("hold_accept_valid", 32'(imem_req_valid), 32'h1);
    chk("hold_accept_addr", imem_req_addr, 32'h0000_0008);
    repeat (8) step();

    // wrap from 0xFFFF_FFFC to 0x0
    base = n_deliv;
    redirect(32'hFFFF_FFF8);
    repeat (12) step();
    checks++;
    if (n_deliv - base < 4) begin
      failures++;
      $display("FAIL wrap_deliveries actual=%0d required>=4", n_deliv - base);
    end

    // random latency, stall, ready and redirects
    rand_lat = 1'b1;
    base = n_deliv;
    since = 0;
    for (int i = 0; i < 300; i++) begin
      StallD = ($urandom_range(0, 3) == 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0 || since >= 40) begin
        since = 0;
        tgt = 32'($urandom_range(0, 32'h3FFF));
        PCSrcE = 1'b1;
        PCTargetE = tgt;
        arm_expect(tgt & ~32'h3);
        exp_req_pc = tgt & ~32'h3;
      end else begin
        since++;
        PCSrcE = 1'b0;
        PCTargetE = 32'h0;
      end
      step();
    end
    PCSrcE = 1'b0;
    StallD = 1'b0;
    imem_req_ready = 1'b1;
    repeat (20) step();
    checks++;
    if (n_deliv - base < 30) begin
      failures++;
      $display("FAIL random_deliveries actual=%0d required>=30", n_deliv - base);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required<200000", $time);
    $fatal(1);
  end

endmodule
